// File: rtl/display_scheduler.sv
// Display page scheduler: periodically requests humidity readings with a timeout,
// and rotates between humidity / setpoint pages with alarm and error overrides.
module display_scheduler #(
    parameter int DWELL_MS   = 3000,
    parameter int SAMPLE_MS  = 1000,
    parameter int TIMEOUT_MS = 100,
    parameter int BLINK_MS   = 250
) (
    input  logic        clk1kHz,
    input  logic        rst,
    input  logic [11:0] humedad_bcd,
    input  logic        humedad_valid,
    input  logic [11:0] setpoint_bcd,
    input  logic        alarma,
    input  logic        btn_next,
    output logic        req_lectura,
    output logic [11:0] dato_bcd,
    output logic [1:0]  pagina
);

    localparam int DW = (DWELL_MS   > 1) ? $clog2(DWELL_MS)   : 1;
    localparam int SW = (SAMPLE_MS  > 1) ? $clog2(SAMPLE_MS)  : 1;
    localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
    localparam int BW = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;

    localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_MS - 1);
    localparam logic [SW-1:0] SAMPLE_LAST  = SW'(SAMPLE_MS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_MS - 1);

    localparam logic [11:0] BLANK = 12'hFFF;

    typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;
    typedef enum logic [1:0] {PG_HUM = 2'b00, PG_SET = 2'b01, PG_ALM = 2'b10, PG_ERR = 2'b11} page_state_t;

    req_state_t  req_state, req_next;
    page_state_t page_state, page_next;

    logic [SW-1:0] sample_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [DW-1:0] dwell_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [11:0]   hum_reg;
    logic          hum_ok;
    logic          err;

    logic          sample_tc;
    logic          bcd_ok;
    logic          issue;
    logic          accept;
    logic          timeout;
    logic          page_hold;
    logic [11:0]   dato_next;

    assign sample_tc = (sample_cnt == SAMPLE_LAST);
    assign bcd_ok    = (humedad_bcd[3:0] <= 4'd9) && (humedad_bcd[7:4] <= 4'd9) &&
                       (humedad_bcd[11:8] <= 4'd9);
    assign page_hold = (page_next == page_state);

    // Free-running sample period counter, independent of page or request state
    always_ff @(posedge clk1kHz) begin
        if (rst)            sample_cnt <= '0;
        else if (sample_tc) sample_cnt <= '0;
        else                sample_cnt <= sample_cnt + 1'b1;
    end

    // Request FSM decisions; a valid reading beats a simultaneous timeout
    always_comb begin
        req_next = req_state;
        issue    = 1'b0;
        accept   = 1'b0;
        timeout  = 1'b0;
        case (req_state)
            REQ_IDLE: begin
                if (sample_tc) begin
                    issue    = 1'b1;
                    req_next = REQ_WAIT;
                end
            end
            REQ_WAIT: begin
                if (humedad_valid && bcd_ok) begin
                    accept   = 1'b1;
                    req_next = REQ_IDLE;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout  = 1'b1;
                    req_next = REQ_IDLE;
                end
            end
            default: req_next = REQ_IDLE;
        endcase
    end

    // Request state, request pulse, timeout counter and reading/err latches
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            req_state   <= REQ_IDLE;
            req_lectura <= 1'b0;
            timeout_cnt <= '0;
            hum_reg     <= 12'h000;
            hum_ok      <= 1'b0;
            err         <= 1'b0;
        end else begin
            req_state   <= req_next;
            req_lectura <= issue;
            if (req_state == REQ_WAIT && req_next == REQ_WAIT) timeout_cnt <= timeout_cnt + 1'b1;
            else                                              timeout_cnt <= '0;
            if (accept) begin
                hum_reg <= humedad_bcd;
                hum_ok  <= 1'b1;
                err     <= 1'b0;
            end else if (timeout) begin
                err     <= 1'b1;
            end
        end
    end

    // Page selection: error beats alarm beats dwell/button rotation
    always_comb begin
        page_next = page_state;
        if (err) begin
            page_next = PG_ERR;
        end else if (alarma) begin
            page_next = PG_ALM;
        end else begin
            case (page_state)
                PG_HUM:  if (dwell_cnt == DWELL_LAST || btn_next) page_next = PG_SET;
                PG_SET:  if (dwell_cnt == DWELL_LAST || btn_next) page_next = PG_HUM;
                default: page_next = PG_HUM;
            endcase
        end
    end

    // Page state plus dwell and blink timers; both restart on any page change
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            page_state  <= PG_HUM;
            dwell_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            page_state <= page_next;
            if ((page_state == PG_HUM || page_state == PG_SET) && page_hold) dwell_cnt <= dwell_cnt + 1'b1;
            else                                                               dwell_cnt <= '0;
            if (page_state == PG_ALM && page_hold) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt   <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end
        end
    end

    // Display value selected from the current page
    always_comb begin
        dato_next = BLANK;
        case (page_state)
            PG_HUM:  dato_next = hum_ok ? hum_reg : BLANK;
            PG_SET:  dato_next = setpoint_bcd;
            PG_ALM:  dato_next = blink_phase ? BLANK : hum_reg;
            default: dato_next = BLANK;
        endcase
    end

    // Registered display outputs, one cycle behind the page state
    always_ff @(posedge clk1kHz) begin
        if (rst) begin
            dato_bcd <= BLANK;
            pagina   <= 2'b00;
        end else begin
            dato_bcd <= dato_next;
            pagina   <= page_state;
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench for display_scheduler with small timing parameters.
module tb_display_scheduler;

    logic        clk1kHz = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] humedad_bcd = 12'h000;
    logic        humedad_valid = 1'b0;
    logic [11:0] setpoint_bcd = 12'h060;
    logic        alarma = 1'b0;
    logic        btn_next = 1'b0;
    logic        req_lectura;
    logic [11:0] dato_bcd;
    logic [1:0]  pagina;

    typedef struct {
        string       name;
        logic [11:0] dato;
        logic [1:0]  pag;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    bit          auto_on = 1'b0;
    logic [11:0] auto_val = 12'h000;

    display_scheduler #(
        .DWELL_MS(10), .SAMPLE_MS(8), .TIMEOUT_MS(4), .BLINK_MS(2)
    ) dut (
        .clk1kHz(clk1kHz), .rst(rst), .humedad_bcd(humedad_bcd),
        .humedad_valid(humedad_valid), .setpoint_bcd(setpoint_bcd),
        .alarma(alarma), .btn_next(btn_next), .req_lectura(req_lectura),
        .dato_bcd(dato_bcd), .pagina(pagina)
    );

    // 10 time-unit clock
    always #5 clk1kHz = ~clk1kHz;

    // Advance one edge at a time, sample on the falling edge, clear pulses,
    // and optionally answer a request on the following edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk1kHz);
            @(negedge clk1kHz);
            edge_n++;
            humedad_valid = 1'b0;
            btn_next = 1'b0;
            if (auto_on && req_lectura) begin
                humedad_valid = 1'b1;
                humedad_bcd = auto_val;
            end
        end
    endtask

    task automatic tick_to(input int k);
        if (k > edge_n) tick(k - edge_n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        auto_on = 1'b0;
        alarma = 1'b0;
        btn_next = 1'b0;
        humedad_valid = 1'b0;
        setpoint_bcd = 12'h060;
        tick(2);
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        sb.push_back('{name: "reset_state", dato: 12'hFFF, pag: 2'b00});
        tick(2);
        e = sb.pop_front(); total++;
        if (dato_bcd !== e.dato || pagina !== e.pag) begin
            bad++;
            $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
        end
        total++;
        if (req_lectura !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_req: req_lectura=%b, expected 0", req_lectura);
        end
    endtask

    task automatic test_first_reading();
        exp_t e;
        do_reset();
        auto_on = 1'b1;
        auto_val = 12'h045;
        sb.push_back('{name: "idle_before_req", dato: 12'hFFF, pag: 2'b00});
        tick_to(7);
        e = sb.pop_front(); total++;
        if (dato_bcd !== e.dato || pagina !== e.pag) begin
            bad++;
            $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
        end
        total++;
        if (req_lectura !== 1'b0) begin
            bad++;
            $display("[TB] FAIL early_req: req_lectura=%b, expected 0", req_lectura);
        end
        tick_to(8);
        total++;
        if (req_lectura !== 1'b1) begin
            bad++;
            $display("[TB] FAIL req_at_8: req_lectura=%b, expected 1", req_lectura);
        end
        sb.push_back('{name: "before_latch", dato: 12'hFFF, pag: 2'b00});
        tick_to(9);
        e = sb.pop_front(); total++;
        if (dato_bcd !== e.dato || pagina !== e.pag) begin
            bad++;
            $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
        end
        total++;
        if (req_lectura !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_one_cycle: req_lectura=%b, expected 0", req_lectura);
        end
        sb.push_back('{name: "hum_shown", dato: 12'h045, pag: 2'b00});
        sb.push_back('{name: "dwell_to_set", dato: 12'h060, pag: 2'b01});
        for (int k = 10; k <= 11; k++) begin
            tick_to(k);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        int   at[6];
        do_reset();
        auto_on = 1'b1;
        auto_val = 12'h045;
        tick_to(13);
        btn_next = 1'b1;
        sb.push_back('{name: "btn_latency", dato: 12'h060, pag: 2'b01});      at[0] = 14;
        sb.push_back('{name: "btn_back_hum", dato: 12'h045, pag: 2'b00});     at[1] = 15;
        sb.push_back('{name: "dwell_restart_hold", dato: 12'h045, pag: 2'b00}); at[2] = 24;
        sb.push_back('{name: "dwell_restart_adv", dato: 12'h060, pag: 2'b01});  at[3] = 25;
        for (int i = 0; i < 4; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
        tick_to(33);
        btn_next = 1'b1;
        sb.push_back('{name: "coincide_adv", dato: 12'h045, pag: 2'b00});     at[0] = 35;
        sb.push_back('{name: "single_adv_hold", dato: 12'h045, pag: 2'b00});  at[1] = 44;
        sb.push_back('{name: "single_adv_next", dato: 12'h060, pag: 2'b01});  at[2] = 45;
        for (int i = 0; i < 3; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   at[4];
        do_reset();
        sb.push_back('{name: "pre_err", dato: 12'h060, pag: 2'b01});   at[0] = 13;
        sb.push_back('{name: "err_page", dato: 12'hFFF, pag: 2'b11});  at[1] = 14;
        for (int i = 0; i < 2; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
        alarma = 1'b1;
        btn_next = 1'b1;
        sb.push_back('{name: "err_over_alarm", dato: 12'hFFF, pag: 2'b11}); at[0] = 15;
        sb.push_back('{name: "err_hold", dato: 12'hFFF, pag: 2'b11});       at[1] = 16;
        for (int i = 0; i < 2; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
        total++;
        if (req_lectura !== 1'b1) begin
            bad++;
            $display("[TB] FAIL req_after_err: req_lectura=%b, expected 1", req_lectura);
        end
        alarma = 1'b0;
        humedad_valid = 1'b1;
        humedad_bcd = 12'h050;
        auto_on = 1'b1;
        auto_val = 12'h050;
        sb.push_back('{name: "err_exit_latency", dato: 12'hFFF, pag: 2'b11}); at[0] = 18;
        sb.push_back('{name: "err_recover", dato: 12'h050, pag: 2'b00});      at[1] = 19;
        sb.push_back('{name: "recover_dwell_hold", dato: 12'h050, pag: 2'b00}); at[2] = 28;
        sb.push_back('{name: "recover_dwell_adv", dato: 12'h060, pag: 2'b01});  at[3] = 29;
        for (int i = 0; i < 4; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
    endtask

    task automatic test_alarm();
        exp_t        e;
        int          at[4];
        logic [11:0] blink_seq[8];
        do_reset();
        auto_on = 1'b1;
        auto_val = 12'h012;
        sb.push_back('{name: "pre_alarm", dato: 12'h012, pag: 2'b00});
        tick_to(10);
        e = sb.pop_front(); total++;
        if (dato_bcd !== e.dato || pagina !== e.pag) begin
            bad++;
            $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
        end
        alarma = 1'b1;
        blink_seq = '{12'h012, 12'h012, 12'hFFF, 12'hFFF, 12'h012, 12'h012, 12'hFFF, 12'hFFF};
        sb.push_back('{name: "alarm_latency", dato: 12'h060, pag: 2'b01});
        for (int i = 0; i < 8; i++)
            sb.push_back('{name: $sformatf("blink_%0d", i), dato: blink_seq[i], pag: 2'b10});
        for (int k = 11; k <= 19; k++) begin
            tick_to(k);
            if (k == 14) btn_next = 1'b1;
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
        alarma = 1'b0;
        sb.push_back('{name: "alarm_exit_latency", dato: 12'h012, pag: 2'b10}); at[0] = 20;
        sb.push_back('{name: "alarm_exit", dato: 12'h012, pag: 2'b00});         at[1] = 21;
        sb.push_back('{name: "alarm_exit_dwell_hold", dato: 12'h012, pag: 2'b00}); at[2] = 30;
        sb.push_back('{name: "alarm_exit_dwell_adv", dato: 12'h060, pag: 2'b01});  at[3] = 31;
        for (int i = 0; i < 4; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
    endtask

    task automatic test_invalid_and_race();
        exp_t e;
        int   at[3];
        do_reset();
        tick_to(8);
        humedad_valid = 1'b1;
        humedad_bcd = 12'h0A3;
        sb.push_back('{name: "bad_bcd_ignored", dato: 12'hFFF, pag: 2'b11});
        tick_to(14);
        e = sb.pop_front(); total++;
        if (dato_bcd !== e.dato || pagina !== e.pag) begin
            bad++;
            $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
        end
        tick_to(19);
        humedad_valid = 1'b1;
        humedad_bcd = 12'h033;
        sb.push_back('{name: "race_latency", dato: 12'hFFF, pag: 2'b11}); at[0] = 21;
        sb.push_back('{name: "race_accept", dato: 12'h033, pag: 2'b00});  at[1] = 22;
        for (int i = 0; i < 2; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
        tick_to(24);
        total++;
        if (req_lectura !== 1'b1) begin
            bad++;
            $display("[TB] FAIL req_before_rst: req_lectura=%b, expected 1", req_lectura);
        end
        tick_to(25);
        rst = 1'b1;
        sb.push_back('{name: "rst_mid_wait", dato: 12'hFFF, pag: 2'b00});
        tick(1);
        e = sb.pop_front(); total++;
        if (dato_bcd !== e.dato || pagina !== e.pag) begin
            bad++;
            $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
        end
        total++;
        if (req_lectura !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_req: req_lectura=%b, expected 0", req_lectura);
        end
        tick(1);
        rst = 1'b0;
        edge_n = 0;
        sb.push_back('{name: "post_rst_no_data", dato: 12'hFFF, pag: 2'b00}); at[0] = 7;
        sb.push_back('{name: "post_rst_no_err", dato: 12'h060, pag: 2'b01});  at[1] = 11;
        for (int i = 0; i < 2; i++) begin
            tick_to(at[i]);
            e = sb.pop_front(); total++;
            if (dato_bcd !== e.dato || pagina !== e.pag) begin
                bad++;
                $display("[TB] FAIL %s: dato=%h pagina=%b, expected dato=%h pagina=%b", e.name, dato_bcd, pagina, e.dato, e.pag);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_first_reading();
        test_rotation();
        test_timeout();
        test_alarm();
        test_invalid_and_race();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
